// File: rtl/regfile_4x_onehot.sv
// regfile_4x_onehot
//
// Four-entry register file fed by the one-hot write select of the 2x4
// decoder. Provides two registered read ports with same-cycle write-to-read
// bypass. Multi-hot write selects suppress the write and set a sticky error.
//
// Ports:
//   CLK      in   rising-edge clock, all state updates on this edge
//   RST      in   synchronous active-high reset
//   WE       in   [3:0] one-hot write select, all-zero means no write
//   WDATA    in   [WIDTH-1:0] write data
//   RE       in   read enable for both ports
//   RADDR_A  in   [1:0] port A read address
//   RADDR_B  in   [1:0] port B read address
//   RDATA_A  out  [WIDTH-1:0] registered read data, port A
//   RDATA_B  out  [WIDTH-1:0] registered read data, port B
//   ERR      out  sticky flag, set by any multi-hot WE
module regfile_4x_onehot #(
    parameter int WIDTH     = 16,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       WE,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE,
    input  logic [1:0]       RADDR_A,
    input  logic [1:0]       RADDR_B,
    output logic [WIDTH-1:0] RDATA_A,
    output logic [WIDTH-1:0] RDATA_B,
    output logic             ERR
);

    logic [WIDTH-1:0] regs [4];
    logic             multi_hot;
    logic [3:0]       write_mask;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    // Classify the write select. Clearing the lowest set bit leaves something
    // behind only when two or more bits are set. The resulting mask is the
    // set of registers actually written this cycle, with register 0 removed
    // when it is hardwired to zero so that neither the write nor the bypass
    // can ever touch it.
    always_comb begin
        multi_hot  = (WE & (WE - 4'd1)) != 4'd0;
        write_mask = multi_hot ? 4'd0 : WE;
        if (ZERO_REG0) begin
            write_mask[0] = 1'b0;
        end
    end

    // Read data that each port will capture on the coming edge: forced zero
    // for a hardwired register 0, the incoming write data when a valid write
    // targets the same register, otherwise the stored contents.
    always_comb begin
        next_a = regs[RADDR_A];
        next_b = regs[RADDR_B];
        if (write_mask[RADDR_A]) begin
            next_a = WDATA;
        end
        if (write_mask[RADDR_B]) begin
            next_b = WDATA;
        end
        if (ZERO_REG0 && (RADDR_A == 2'd0)) begin
            next_a = '0;
        end
        if (ZERO_REG0 && (RADDR_B == 2'd0)) begin
            next_b = '0;
        end
    end

    // Register array, read ports and sticky error. Reset wins over every
    // other input in the same cycle, so a colliding write or read is lost.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            RDATA_A <= '0;
            RDATA_B <= '0;
            ERR     <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (write_mask[i]) begin
                    regs[i] <= WDATA;
                end
            end
            if (multi_hot) begin
                ERR <= 1'b1;
            end
            if (RE) begin
                RDATA_A <= next_a;
                RDATA_B <= next_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_4x_onehot.sv
// tb_regfile_4x_onehot
//
// Table-driven bench for regfile_4x_onehot. Two instances share the same
// stimulus: dut_z hardwires register 0 to zero, dut_n treats it as a normal
// register. Each table row is one clock cycle with the outputs expected right
// after that edge. A short hand-written sequence covers the register 0
// difference between the two instances.
module tb_regfile_4x_onehot;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [3:0]       we;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [1:0]       raddr_a;
    logic [1:0]       raddr_b;
    logic [WIDTH-1:0] rdata_a_z, rdata_b_z, rdata_a_n, rdata_b_n;
    logic             err_z, err_n;

    int total;
    int bad;

    typedef struct {
        logic             rst;
        logic [3:0]       we;
        logic [WIDTH-1:0] wdata;
        logic             re;
        logic [1:0]       ra;
        logic [1:0]       rb;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        logic             exp_err;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    regfile_4x_onehot #(.WIDTH(WIDTH), .ZERO_REG0(1'b1)) dut_z (
        .CLK(clk), .RST(rst), .WE(we), .WDATA(wdata), .RE(re),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b),
        .RDATA_A(rdata_a_z), .RDATA_B(rdata_b_z), .ERR(err_z)
    );

    regfile_4x_onehot #(.WIDTH(WIDTH), .ZERO_REG0(1'b0)) dut_n (
        .CLK(clk), .RST(rst), .WE(we), .WDATA(wdata), .RE(re),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b),
        .RDATA_A(rdata_a_n), .RDATA_B(rdata_b_n), .ERR(err_n)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then wait for the edge and settle past it.
    task automatic apply_stimulus(input logic r, input logic [3:0] w,
                                  input logic [WIDTH-1:0] d, input logic e,
                                  input logic [1:0] a, input logic [1:0] b);
        rst     = r;
        we      = w;
        wdata   = d;
        re      = e;
        raddr_a = a;
        raddr_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [WIDTH-1:0] actual,
                                input logic [WIDTH-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        we      = 4'd0;
        wdata   = '0;
        re      = 1'b0;
        raddr_a = 2'd0;
        raddr_b = 2'd0;

        //            rst   we       wdata     re    ra    rb    exp_a     exp_b     err
        vecs[0]  = '{1'b1, 4'b0000, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 2'd1, 2'd3, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 4'b0010, 16'hBEEF, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 2'd1, 2'd0, 16'hBEEF, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 4'b1000, 16'h1234, 1'b0, 2'd0, 2'd0, 16'hBEEF, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 2'd0, 2'd3, 16'h0000, 16'h1234, 1'b0};
        vecs[7]  = '{1'b0, 4'b0100, 16'h0001, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h1234, 1'b0};
        vecs[8]  = '{1'b0, 4'b0100, 16'hA5A5, 1'b1, 2'd2, 2'd2, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[9]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 2'd2, 2'd1, 16'hA5A5, 16'hBEEF, 1'b0};
        vecs[10] = '{1'b0, 4'b0001, 16'hFFFF, 1'b1, 2'd0, 2'd3, 16'h0000, 16'h1234, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 4'b0010, 16'h1111, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 4'b1000, 16'h3333, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[14] = '{1'b0, 4'b1010, 16'hDEAD, 1'b1, 2'd1, 2'd3, 16'h1111, 16'h3333, 1'b1};
        vecs[15] = '{1'b0, 4'b0100, 16'h7777, 1'b1, 2'd2, 2'd1, 16'h7777, 16'h1111, 1'b1};
        vecs[16] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 2'd3, 2'd2, 16'h3333, 16'h7777, 1'b1};
        vecs[17] = '{1'b0, 4'b0010, 16'h2222, 1'b0, 2'd1, 2'd3, 16'h3333, 16'h7777, 1'b1};
        vecs[18] = '{1'b0, 4'b1000, 16'h4444, 1'b0, 2'd1, 2'd3, 16'h3333, 16'h7777, 1'b1};
        vecs[19] = '{1'b0, 4'b0100, 16'h5555, 1'b0, 2'd1, 2'd3, 16'h3333, 16'h7777, 1'b1};
        vecs[20] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 2'd1, 2'd3, 16'h2222, 16'h4444, 1'b1};
        vecs[21] = '{1'b1, 4'b0010, 16'h9999, 1'b1, 2'd1, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[22] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 2'd1, 2'd2, 16'h0000, 16'h0000, 1'b0};
        vecs[23] = '{1'b0, 4'b0111, 16'hAAAA, 1'b1, 2'd1, 2'd2, 16'h0000, 16'h0000, 1'b1};
        vecs[24] = '{1'b1, 4'b0000, 16'h0000, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0};

        @(negedge clk);
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].we, vecs[i].wdata,
                           vecs[i].re, vecs[i].ra, vecs[i].rb);
            check_output($sformatf("row%0d_rdata_a", i), rdata_a_z, vecs[i].exp_a);
            check_output($sformatf("row%0d_rdata_b", i), rdata_b_z, vecs[i].exp_b);
            check_output($sformatf("row%0d_err", i), {15'd0, err_z}, {15'd0, vecs[i].exp_err});
        end

        // Register 0 write with a same-cycle read: hardwired instance reads
        // zero, normal instance bypasses the write data.
        apply_stimulus(1'b0, 4'b0001, 16'hFFFF, 1'b1, 2'd0, 2'd0);
        check_output("zero_bypass_z_a", rdata_a_z, 16'h0000);
        check_output("zero_bypass_z_err", {15'd0, err_z}, 16'h0000);
        check_output("zero_bypass_n_a", rdata_a_n, 16'hFFFF);
        check_output("zero_bypass_n_b", rdata_b_n, 16'hFFFF);
        check_output("zero_bypass_n_err", {15'd0, err_n}, 16'h0000);

        // Later read of register 0 from stored state.
        apply_stimulus(1'b0, 4'b0000, 16'h0000, 1'b1, 2'd0, 2'd1);
        check_output("zero_later_z_a", rdata_a_z, 16'h0000);
        check_output("zero_later_n_a", rdata_a_n, 16'hFFFF);
        check_output("zero_later_n_b", rdata_b_n, 16'h0000);

        // Sticky error survives several valid writes until reset.
        apply_stimulus(1'b0, 4'b1100, 16'h0BAD, 1'b0, 2'd0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 4'b0010 << k, 16'h0101, 1'b0, 2'd0, 2'd0);
            check_output($sformatf("sticky_n_err%0d", k), {15'd0, err_n}, 16'h0001);
        end
        apply_stimulus(1'b1, 4'b0000, 16'h0000, 1'b0, 2'd0, 2'd0);
        check_output("sticky_clear_n_err", {15'd0, err_n}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_4x_onehot.md
Name: regfile_4x_onehot

Overview:
- Four-entry register file, directly downstream of the 2x4 decoder.
- Consumes the decoder's one-hot write-select vector and performs the register write on the clock edge.
- Provides two registered read ports, with same-cycle write-to-read bypass, for the 5-stage pipeline's decode stage.
- Detects non-one-hot select vectors, suppresses the write, and flags the error.

Parameters:
- WIDTH, 16, data width of each register and of the read/write data ports.
- ZERO_REG0, 1, when 1 register 0 always reads as zero and ignores writes; when 0 it is a normal register.

Ports:
- CLK  input  1  rising-edge clock; all state updates on this edge.
- RST  input  1  synchronous, active-high reset, sampled on rising CLK.
- WE  input  4  one-hot write select from the 2x4 decoder; bit i selects register i; all-zero means no write.
- WDATA  input  WIDTH  write data.
- RE  input  1  read enable for both read ports.
- RADDR_A  input  2  read address, port A.
- RADDR_B  input  2  read address, port B.
- RDATA_A  output  WIDTH  registered read data, port A.
- RDATA_B  output  WIDTH  registered read data, port B.
- ERR  output  1  sticky flag: set on any multi-hot WE.

Behaviour:
- Reset (RST=1 at edge): all four registers <= 0, RDATA_A <= 0, RDATA_B <= 0, ERR <= 0. RST overrides every other input in that cycle: no write, no read, no error capture.
- Write classification, evaluated each cycle when RST=0:
  - popcount(WE)=0: idle.
  - popcount(WE)=1: valid.
  - popcount(WE)>=2: illegal.
- Valid write: register i <= WDATA at the edge. If ZERO_REG0=1 and i=0, the write is dropped silently; it is not an error.
- Illegal write: no register changes; ERR <= 1. ERR stays 1 until RST.
- Read latency is one cycle. When RE=1 at edge N, RDATA_A/B show the addressed contents after edge N. When RE=0, RDATA_A/B hold their previous values.
- Bypass: if RE=1 and a valid write targets the register addressed by port A (or B) in the same cycle, that port captures WDATA, not the old contents. Bypass never applies to register 0 when ZERO_REG0=1 (reads 0). An illegal WE never bypasses: ports read the stored contents.
- Both ports may address the same register. Both may bypass simultaneously and return identical data.
- ZERO_REG0=1: any read of address 0 returns 0 regardless of stored state or WE.
- Reset mid-operation: a write or read presented in the same cycle as RST is discarded. The first post-reset read returns 0 for every register.
- All data paths are exactly WIDTH bits wide; there is no arithmetic or extension.

Test Plan:
- Reset: assert RST 2 cycles, then RE=1 with RADDR_A=1, RADDR_B=3 -> RDATA_A=0, RDATA_B=0, ERR=0.
- Basic write/read: WE=4'b0010, WDATA=16'hBEEF; next cycle RE=1, RADDR_A=1 -> RDATA_A=16'hBEEF one cycle later. WE=4'b1000 with 16'h1234, read via B -> 16'h1234.
- Bypass: register 2 holds 16'h0001. In the same cycle drive WE=4'b0100, WDATA=16'hA5A5, RE=1, RADDR_A=2, RADDR_B=2 -> both ports = 16'hA5A5 after that edge.
- Zero register (ZERO_REG0=1): WE=4'b0001, WDATA=16'hFFFF, with a same-cycle read of address 0 -> RDATA_A=0 and ERR=0; a later read of address 0 -> RDATA_A=0. With ZERO_REG0=0 the same sequence returns 16'hFFFF.
- Illegal select: register 1 holds 16'h1111 and register 3 holds 16'h3333. Drive WE=4'b1010, WDATA=16'hDEAD, RE=1, RADDR_A=1, RADDR_B=3 -> ports read 16'h1111 and 16'h3333, and ERR=1 from the next cycle. ERR stays 1 through later valid writes; RST clears it.
- Hold and reset collision: with RE=0 the outputs hold over 3 cycles while registers are written. Present WE=4'b0010 with RST=1 -> register 1 still reads 0 afterwards.
